// File: rtl/hdmi_video_timing_pkg.sv
// Purpose: shared constants for hdmi_video_timing: default 640x480@60 mode, YES/NO, counter width, row-advance helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package hdmi_video_timing_pkg;

    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;

    // Raster counters are 12 bits, so H/V totals must not exceed 4096.
    localparam int CNT_W = 12;

    // Default mode: 640x480@60, totals 800 x 525.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_ROWS = 24;

    // Advance a text row index by one, wrapping after the last row.
    function automatic logic [4:0] next_row(input logic [4:0] cur, input logic [4:0] last);
        return (cur == last) ? 5'd0 : cur + 5'd1;
    endfunction

endpackage

// File: rtl/hdmi_video_timing.sv
// Purpose: raster timing generator (active, syncs, line/frame start) plus frame-synchronous scroll register for the text mapper.
// Latency: every output is registered and reflects counter state (h, v) one cycle later.
// Backpressure: none; scroll requests are always accepted, coalesced while pending, applied at h==0 of the first blank line, acked once.
//
// Ports:
//   clk         pixel clock
//   reset_n     synchronous active-low reset
//   scroll_req  one-cycle request to advance top_row by one
//   scroll_ack  one-cycle pulse, coincident with the new out_top_row
//   out_active  pixel in active region
//   out_h_sync  horizontal sync at H_SYNC_POL when asserted
//   out_v_sync  vertical sync at V_SYNC_POL when asserted
//   out_h_start first active pixel of a line
//   out_v_start first active line of a frame (whole active part of that line)
//   out_top_row first text row shown this frame
module hdmi_video_timing
    import hdmi_video_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FRONT    = DEF_H_FRONT,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BACK     = DEF_H_BACK,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FRONT    = DEF_V_FRONT,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BACK     = DEF_V_BACK,
    parameter logic H_SYNC_POL = NO,
    parameter logic V_SYNC_POL = NO,
    parameter int   ROWS       = DEF_ROWS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scroll_req,
    output logic       scroll_ack,
    output logic       out_active,
    output logic       out_h_sync,
    output logic       out_v_sync,
    output logic       out_h_start,
    output logic       out_v_start,
    output logic [4:0] out_top_row
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Region boundaries pre-cast to counter width so all compares are same-width.
    localparam logic [CNT_W-1:0] L_H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] L_HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] L_HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] L_V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] L_VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] L_VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [4:0]       L_ROW_LAST = 5'(ROWS - 1);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_pending;
    logic [4:0]       r_top_row;
    logic             r_scroll_ack;
    logic             r_active;
    logic             r_h_sync;
    logic             r_v_sync;
    logic             r_h_start;
    logic             r_v_start;

    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_hs_on;
    logic w_vs_on;
    logic w_apply_pt;
    logic w_take;

    always_comb begin
        w_h_last   = (r_h == L_H_LAST);
        w_v_last   = (r_v == L_V_LAST);
        w_active   = (r_h < L_H_ACT) && (r_v < L_V_ACT);
        w_hs_on    = (r_h >= L_HS_BEG) && (r_h < L_HS_END);
        w_vs_on    = (r_v >= L_VS_BEG) && (r_v < L_VS_END);
        // Apply point is the first pixel of the first blank line, so the new
        // top_row is settled long before the next frame's first active line.
        w_apply_pt = (r_h == '0) && (r_v == L_V_ACT);
        // A request landing exactly on the apply point is served by this apply.
        w_take     = w_apply_pt && (r_pending || scroll_req);
    end

    // Raster counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Registered raster outputs, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active  <= NO;
            r_h_start <= NO;
            r_v_start <= NO;
            r_h_sync  <= ~H_SYNC_POL;
            r_v_sync  <= ~V_SYNC_POL;
        end else begin
            r_active  <= w_active;
            r_h_start <= w_active && (r_h == '0);
            r_v_start <= w_active && (r_v == '0);
            r_h_sync  <= w_hs_on ? H_SYNC_POL : ~H_SYNC_POL;
            r_v_sync  <= w_vs_on ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

    // Scroll handshake: pending coalesces requests; the apply point always
    // clears it because either it is consumed or nothing was pending.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending    <= NO;
            r_top_row    <= '0;
            r_scroll_ack <= NO;
        end else begin
            r_pending    <= w_apply_pt ? NO : (r_pending || scroll_req);
            r_scroll_ack <= w_take;
            if (w_take) begin
                r_top_row <= next_row(r_top_row, L_ROW_LAST);
            end
        end
    end

    assign scroll_ack  = r_scroll_ack;
    assign out_active  = r_active;
    assign out_h_sync  = r_h_sync;
    assign out_v_sync  = r_v_sync;
    assign out_h_start = r_h_start;
    assign out_v_start = r_v_start;
    assign out_top_row = r_top_row;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Purpose: directed self-checking bench for hdmi_video_timing on a reduced raster (15 x 10) with both sync polarities.
// Latency: n/a.
// Backpressure: n/a.
module tb_hdmi_video_timing;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HT = HA + HF + HS + HB;   // 15
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VA + VF + VS + VB;   // 10
    localparam int FR = HT * VT;             // 150 cycles per frame
    // Apply point is counter index VA*HT; its effect is visible after the next edge.
    localparam int APPLY_N = VA * HT + 1;    // 91

    logic       clk;
    logic       reset_n;
    logic       scroll_req;
    logic       ack;
    logic       act;
    logic       hs;
    logic       vs;
    logic       hst;
    logic       vst;
    logic [4:0] row;
    logic       p_ack;
    logic       p_act;
    logic       p_hs;
    logic       p_vs;
    logic       p_hst;
    logic       p_vst;
    logic [4:0] p_row;

    int total;
    int bad;
    int n;      // posedges since reset release; counters hold index n, outputs reflect n-1

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .ROWS(24)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .scroll_req(scroll_req), .scroll_ack(ack),
        .out_active(act), .out_h_sync(hs), .out_v_sync(vs),
        .out_h_start(hst), .out_v_start(vst), .out_top_row(row)
    );

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .ROWS(24)
    ) u_dut_p (
        .clk(clk), .reset_n(reset_n), .scroll_req(scroll_req), .scroll_ack(p_ack),
        .out_active(p_act), .out_h_sync(p_hs), .out_v_sync(p_vs),
        .out_h_start(p_hst), .out_v_start(p_vst), .out_top_row(p_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected raster values for output index idx (counter state one cycle earlier).
    function automatic bit e_act(input int idx);
        int h;
        int v;
        h = idx % HT;
        v = (idx / HT) % VT;
        return (h < HA) && (v < VA);
    endfunction

    function automatic bit e_hst(input int idx);
        return e_act(idx) && ((idx % HT) == 0);
    endfunction

    function automatic bit e_vst(input int idx);
        return e_act(idx) && (((idx / HT) % VT) == 0);
    endfunction

    function automatic bit e_hs_on(input int idx);
        int h;
        h = idx % HT;
        return (h >= HA + HF) && (h < HA + HF + HS);
    endfunction

    function automatic bit e_vs_on(input int idx);
        int v;
        v = (idx / HT) % VT;
        return (v >= VA + VF) && (v < VA + VF + VS);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n = n + 1;
    endtask

    task automatic hold_reset(input int cycles);
        reset_n    = 1'b0;
        scroll_req = 1'b0;
        repeat (cycles) tick();
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        hold_reset(3);
        got = {act, hst, vst, hs, vs, ack, p_hs, p_vs};
        total++;
        if (got !== 8'b000_11_0_00) begin
            bad++;
            $display("FAIL reset_flags: got %b want %b", got, 8'b000_11_0_00);
        end
        total++;
        if (row !== 5'd0 || p_row !== 5'd0) begin
            bad++;
            $display("FAIL reset_top_row: got %0d/%0d want 0/0", row, p_row);
        end
    endtask

    task automatic test_first_active();
        logic [2:0] got;
        hold_reset(2);
        release_reset();
        tick();
        got = {act, hst, vst};
        total++;
        if (got !== 3'b111) begin
            bad++;
            $display("FAIL first_cycle: got %b want 111", got);
        end
        tick();
        got = {act, hst, vst};
        total++;
        if (got !== 3'b101) begin
            bad++;
            $display("FAIL second_cycle: got %b want 101", got);
        end
    endtask

    task automatic test_raster();
        int e_a, e_h, e_v, e_s, e_ps;
        int c_act, c_hst, c_vst, c_hs, c_vs;
        e_a = 0; e_h = 0; e_v = 0; e_s = 0; e_ps = 0;
        c_act = 0; c_hst = 0; c_vst = 0; c_hs = 0; c_vs = 0;
        hold_reset(2);
        release_reset();
        for (int k = 0; k < 2 * FR; k++) begin
            tick();
            if (act !== e_act(n - 1) || p_act !== e_act(n - 1)) e_a++;
            if (hst !== e_hst(n - 1)) e_h++;
            if (vst !== e_vst(n - 1)) e_v++;
            if (hs !== !e_hs_on(n - 1) || vs !== !e_vs_on(n - 1)) e_s++;
            if (p_hs !== e_hs_on(n - 1) || p_vs !== e_vs_on(n - 1)) e_ps++;
            if (act === 1'b1) c_act++;
            if (hst === 1'b1) c_hst++;
            if (vst === 1'b1) c_vst++;
            if (hs === 1'b0) c_hs++;
            if (vs === 1'b0) c_vs++;
        end
        total++;
        if (c_act !== 2 * HA * VA) begin
            bad++;
            $display("FAIL active_count: got %0d want %0d", c_act, 2 * HA * VA);
        end
        total++;
        if (c_hst !== 2 * VA) begin
            bad++;
            $display("FAIL h_start_count: got %0d want %0d", c_hst, 2 * VA);
        end
        total++;
        if (c_vst !== 2 * HA) begin
            bad++;
            $display("FAIL v_start_count: got %0d want %0d", c_vst, 2 * HA);
        end
        total++;
        if (c_hs !== 2 * VT * HS || c_vs !== 2 * VS * HT) begin
            bad++;
            $display("FAIL sync_low_count: got %0d/%0d want %0d/%0d", c_hs, c_vs, 2 * VT * HS, 2 * VS * HT);
        end
        total++;
        if (e_a + e_h + e_v !== 0) begin
            bad++;
            $display("FAIL raster_position: got %0d/%0d/%0d bad cycles want 0", e_a, e_h, e_v);
        end
        total++;
        if (e_s !== 0) begin
            bad++;
            $display("FAIL sync_window_low: got %0d bad cycles want 0", e_s);
        end
        total++;
        if (e_ps !== 0) begin
            bad++;
            $display("FAIL sync_window_high: got %0d bad cycles want 0", e_ps);
        end
    endtask

    task automatic test_single_scroll();
        int early;
        int acks;
        early = 0;
        acks = 0;
        hold_reset(2);
        release_reset();
        for (int k = 0; k < 2 * FR; k++) begin
            scroll_req = (n == 20);
            tick();
            if (n < APPLY_N && row !== 5'd0) early++;
            if (ack === 1'b1) acks++;
            if (n == APPLY_N) begin
                total++;
                if ({ack, row} !== 6'b1_00001) begin
                    bad++;
                    $display("FAIL single_apply: got ack=%b row=%0d want ack=1 row=1", ack, row);
                end
            end
        end
        scroll_req = 1'b0;
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL single_early: got %0d early changes want 0", early);
        end
        total++;
        if (acks !== 1 || row !== 5'd1) begin
            bad++;
            $display("FAIL single_total: got acks=%0d row=%0d want 1/1", acks, row);
        end
    endtask

    task automatic test_coalesce();
        int acks;
        acks = 0;
        hold_reset(2);
        release_reset();
        for (int k = 0; k < 2 * FR; k++) begin
            scroll_req = (n == 10) || (n == 30) || (n == 50);
            tick();
            if (ack === 1'b1) acks++;
        end
        scroll_req = 1'b0;
        total++;
        if (acks !== 1 || row !== 5'd1) begin
            bad++;
            $display("FAIL coalesce: got acks=%0d row=%0d want 1/1", acks, row);
        end
    endtask

    task automatic test_same_cycle();
        int acks;
        acks = 0;
        hold_reset(2);
        release_reset();
        for (int k = 0; k < 2 * FR; k++) begin
            scroll_req = (n == APPLY_N - 1);
            tick();
            if (ack === 1'b1) acks++;
            if (n == APPLY_N) begin
                total++;
                if ({ack, row} !== 6'b1_00001) begin
                    bad++;
                    $display("FAIL same_cycle_apply: got ack=%b row=%0d want ack=1 row=1", ack, row);
                end
            end
        end
        scroll_req = 1'b0;
        total++;
        if (acks !== 1) begin
            bad++;
            $display("FAIL same_cycle_acks: got %0d want 1", acks);
        end
    endtask

    task automatic test_wrap();
        int acks;
        int errs;
        acks = 0;
        errs = 0;
        hold_reset(2);
        release_reset();
        for (int k = 0; k < 26 * FR; k++) begin
            scroll_req = ((n % FR) == 20);
            tick();
            if (ack === 1'b1) acks++;
            // top_row seen at each first active line equals number of applies so far.
            if (vst === 1'b1 && row !== 5'(((n - 1) / FR) % 24)) errs++;
            if (p_vst === 1'b1 && p_row !== 5'(((n - 1) / FR) % 24)) errs++;
            if (n == 22 * FR + APPLY_N) begin
                total++;
                if (row !== 5'd23) begin
                    bad++;
                    $display("FAIL wrap_row23: got %0d want 23", row);
                end
            end
            if (n == 23 * FR + APPLY_N) begin
                total++;
                if ({ack, row} !== 6'b1_00000) begin
                    bad++;
                    $display("FAIL wrap_to_zero: got ack=%b row=%0d want ack=1 row=0", ack, row);
                end
            end
        end
        scroll_req = 1'b0;
        total++;
        if (acks !== 26 || errs !== 0) begin
            bad++;
            $display("FAIL wrap_sequence: got acks=%0d row_errs=%0d want 26/0", acks, errs);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        logic [7:0] got;
        acks = 0;
        hold_reset(2);
        release_reset();
        for (int k = 0; k < 65; k++) begin
            scroll_req = (n == 10);
            tick();
        end
        scroll_req = 1'b0;
        hold_reset(1);
        got = {act, hst, vst, hs, vs, ack, p_hs, p_vs};
        total++;
        if (got !== 8'b000_11_0_00 || row !== 5'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b row=%0d want 00011000 row=0", got, row);
        end
        hold_reset(1);
        release_reset();
        tick();
        total++;
        if ({act, hst, vst} !== 3'b111) begin
            bad++;
            $display("FAIL mid_reset_restart: got %b want 111", {act, hst, vst});
        end
        for (int k = 0; k < 2 * FR; k++) begin
            tick();
            if (ack === 1'b1) acks++;
        end
        total++;
        if (acks !== 0 || row !== 5'd0) begin
            bad++;
            $display("FAIL mid_reset_pending: got acks=%0d row=%0d want 0/0", acks, row);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        n          = 0;
        reset_n    = 1'b0;
        scroll_req = 1'b0;
        test_reset();
        test_first_active();
        test_raster();
        test_single_scroll();
        test_coalesce();
        test_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
